// File: rtl/clock_ctrl.sv
// Run/halt/single-step controller for the CPU clock generator.
// Gates the generator through active-low ctrlen and counts completed CPU cycles seen on iclk.
module clock_ctrl #(
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned MAX_USTEPS = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iclk,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             step_mode,
    input  logic             halt_req,
    input  logic             instr_end,
    output logic             ctrlen,
    output logic             running,
    output logic             halted,
    output logic             step_overrun,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned ST_W = $clog2(MAX_USTEPS + 1);

    typedef enum logic [1:0] {
        S_HALTED,
        S_RUN,
        S_STEP_CYC,
        S_STEP_INS
    } state_t;

    // Button path: bit 0 = run, bit 1 = step
    logic [1:0]      w_btn_raw;
    logic [1:0]      r_btn_s1;
    logic [1:0]      r_btn_s2;
    logic [1:0]      r_btn_stable;
    logic [1:0]      r_btn_prev;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [1:0]      w_press;

    assign w_btn_raw = {step_btn, run_btn};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_s1     <= '0;
            r_btn_s2     <= '0;
            r_btn_stable <= '0;
            r_btn_prev   <= '1;
            for (int unsigned i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_btn_s1   <= w_btn_raw;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_stable;
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_btn_s2[i] == r_btn_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                    r_btn_stable[i] <= r_btn_s2[i];
                    r_db_cnt[i]     <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press = r_btn_stable & ~r_btn_prev;

    // iclk path: history is pinned high while gated so no boundary can be seen
    logic r_iclk_s1;
    logic r_iclk_s2;
    logic r_iclk_hist;
    logic r_bnd;
    logic r_ctrlen;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iclk_s1   <= 1'b0;
            r_iclk_s2   <= 1'b0;
            r_iclk_hist <= 1'b1;
            r_bnd       <= 1'b0;
        end else begin
            r_iclk_s1   <= iclk;
            r_iclk_s2   <= r_iclk_s1;
            r_iclk_hist <= r_ctrlen ? 1'b1 : r_iclk_s2;
            r_bnd       <= r_iclk_s2 & ~r_iclk_hist & ~r_ctrlen;
        end
    end

    // FSM
    state_t          r_state;
    state_t          w_state_next;
    logic [ST_W-1:0] r_ustep;
    logic [ST_W-1:0] w_ustep_next;
    logic            r_ovr;
    logic            w_ovr_next;
    logic            r_running;
    logic            r_halted;
    logic [CNT_W-1:0] r_cnt;

    always_comb begin
        w_state_next = r_state;
        w_ustep_next = r_ustep;
        w_ovr_next   = r_ovr;
        case (r_state)
            S_HALTED: begin
                if (w_press[0]) begin
                    w_state_next = S_RUN;
                end else if (w_press[1]) begin
                    w_state_next = step_mode ? S_STEP_INS : S_STEP_CYC;
                    w_ustep_next = '0;
                    w_ovr_next   = 1'b0;
                end
            end
            S_RUN: begin
                if (w_press[0] || (r_bnd && halt_req)) begin
                    w_state_next = S_HALTED;
                end
            end
            S_STEP_CYC: begin
                if (r_bnd) begin
                    w_state_next = S_HALTED;
                end
            end
            S_STEP_INS: begin
                if (r_bnd) begin
                    w_ustep_next = r_ustep + 1'b1;
                    if (instr_end || halt_req) begin
                        w_state_next = S_HALTED;
                    end else if (r_ustep == ST_W'(MAX_USTEPS - 1)) begin
                        w_state_next = S_HALTED;
                        w_ovr_next   = 1'b1;
                    end
                end
            end
            default: w_state_next = S_HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_HALTED;
            r_ustep   <= '0;
            r_ovr     <= 1'b0;
            r_ctrlen  <= 1'b1;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ustep   <= w_ustep_next;
            r_ovr     <= w_ovr_next;
            r_ctrlen  <= (w_state_next == S_HALTED);
            r_running <= (w_state_next != S_HALTED);
            r_halted  <= (w_state_next == S_HALTED);
            if (r_bnd) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign ctrlen       = r_ctrlen;
    assign running      = r_running;
    assign halted       = r_halted;
    assign step_overrun = r_ovr;
    assign cycle_count  = r_cnt;

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Run/halt/single-step controller sitting directly upstream of the CPU clock generator. It drives the generator's active-low `ctrlen` enable and watches the generator's `iclk` phase to detect completed CPU cycles. It supports free run, single-cycle step, whole-instruction step and HLT-instruction stop. It runs on the free-running system clock.

Parameters:
DEBOUNCE, 4, consecutive identical samples required before a button level is accepted
MAX_USTEPS, 8, cycle budget for an instruction step before overrun abort
CNT_W, 16, width of cycle_count

Ports:
clk  in  1  free-running system clock
reset  in  1  synchronous, active-high reset
iclk  in  1  CPU inverted-phase clock from clock generator; rising edge = CPU cycle complete
run_btn  in  1  raw run/stop toggle button, active-high
step_btn  in  1  raw step button, active-high
step_mode  in  1  0 = step one cycle, 1 = step one instruction; sampled when the step press is accepted
halt_req  in  1  HLT decoded by control unit, level
instr_end  in  1  microcode last-step flag, sampled at cycle boundary
ctrlen  out  1  clock-generator enable, active-low (0 = CPU clocks pass)
running  out  1  1 in any non-HALTED state
halted  out  1  1 in HALTED state
step_overrun  out  1  sticky; instruction step exceeded MAX_USTEPS
cycle_count  out  CNT_W  completed CPU cycles since reset

Behaviour:
- Reset (sync, high), effective next clk edge:
  - state=HALTED, ctrlen=1, running=0, halted=1, step_overrun=0, cycle_count=0.
  - Debouncers and step counter cleared; edge-detector history=1.
- Buttons: each button has a DEBOUNCE-sample stable filter followed by a rising-edge detector. Result is one 1-clk press pulse per accepted low→high transition. No auto-repeat while held.
- iclk path:
  - 2-flop synchronizer, then rising-edge detect: boundary pulse 3 clk after iclk rises.
  - While ctrlen=1 the history flop is forced to 1. No boundary is possible while the clock is gated, and tristated or X input is ignored.
- cycle_count: +1 per boundary pulse; wraps all-ones→0.
- FSM:
  - HALTED: ctrlen=1.
    - run press → RUN.
    - Otherwise step press → STEP_CYC (step_mode=0) or STEP_INS (step_mode=1).
    - run and step presses in the same clk: run wins.
    - Entering any step state clears the step counter and step_overrun.
  - RUN: ctrlen=0.
    - run press → HALTED at once.
    - At a boundary with halt_req=1 → HALTED.
    - Step presses ignored.
  - STEP_CYC: ctrlen=0. First boundary → HALTED.
  - STEP_INS: ctrlen=0. Step counter +1 per boundary.
    - Boundary with instr_end=1 or halt_req=1 → HALTED.
    - Boundary where counter reaches MAX_USTEPS without instr_end → HALTED, step_overrun=1.
  - Run/step presses are ignored in step states.
- Stop timing: the transition to HALTED and ctrlen=1 are registered in the same clk edge that consumes the boundary pulse. The generator latches ctrlen on the falling edge of iclk half a CPU cycle later, so exactly the in-flight cycle completes.
- halt_req is acted on only at boundaries, never mid-cycle.
- A press arriving in the same clk as a stopping boundary is lost.
- Outputs are registered; `running` and `halted` are mutually exclusive and never both 0.

Test Plan:
- Reset with iclk=1 held → ctrlen=1, halted=1, cycle_count=0, no boundary counted over 50 clk.
- HALTED, run_btn high for 6 clk (DEBOUNCE=4) → exactly one transition to RUN, ctrlen=0. After 10 iclk rising edges → cycle_count=10.
- RUN, halt_req=1 asserted mid-cycle → ctrlen stays 0 until the next boundary, then 1. cycle_count increments by exactly 1 more.
- HALTED, step_mode=0, step press → exactly 1 boundary counted, then HALTED. Button held 100 clk gives no second step.
- step_mode=1, instr_end asserted on the 3rd boundary → cycle_count +3, HALTED, step_overrun=0. With instr_end never asserted → +8 cycles, step_overrun=1.
- Simultaneous run+step press in HALTED → RUN. cycle_count preset near 0xFFFF plus 2 boundaries → wraps to 0x0001. Reset pulse during RUN → ctrlen=1 next clk, all outputs return to reset values.
